// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder and the datapath extender:
// format codes, error codes and the sign bit position of each format.
package imm_encoder_pkg;

  // Immediate formats (same encoding as the extender's imsrc)
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Error codes carried with each result
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  // Sign bit of each format's encodable immediate
  localparam int unsigned RANGE_BIT_I = 11;
  localparam int unsigned RANGE_BIT_S = 11;
  localparam int unsigned RANGE_BIT_B = 12;
  localparam int unsigned RANGE_BIT_J = 20;

  // True when v equals its own sign-extension from bit msb,
  // i.e. bits [31:msb] are all zeros or all ones.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational core: checks an immediate against its format and packs it
// into the instruction fields of base. On error the immediate fields of base
// are zeroed instead.
module imm_encoder_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  imsrc,
  output logic [31:0] word,
  output logic [1:0]  err_code
);

  logic [31:0] packed_word;
  logic [31:0] keep_mask;
  logic        in_range;
  logic        misaligned;

  // Per-format packing, mask of non-immediate bits and range/alignment test
  always_comb begin
    packed_word = base;
    keep_mask   = 32'hFFFF_FFFF;
    in_range    = 1'b1;
    misaligned  = 1'b0;
    case (imsrc)
      IMM_I: begin
        packed_word = {imm[11:0], base[19:0]};
        keep_mask   = 32'h000F_FFFF;
        in_range    = fits_signed(imm, RANGE_BIT_I);
      end
      IMM_S: begin
        packed_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        keep_mask   = 32'h01FF_F07F;
        in_range    = fits_signed(imm, RANGE_BIT_S);
      end
      IMM_B: begin
        packed_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        keep_mask   = 32'h01FF_F07F;
        in_range    = fits_signed(imm, RANGE_BIT_B);
        misaligned  = imm[0];
      end
      IMM_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        keep_mask   = 32'h0000_0FFF;
        in_range    = fits_signed(imm, RANGE_BIT_J);
        misaligned  = imm[0];
      end
    endcase
  end

  // RANGE outranks ALIGN; any error emits base with its immediate fields cleared
  always_comb begin
    if (!in_range) begin
      err_code = ERR_RANGE;
    end else if (misaligned) begin
      err_code = ERR_ALIGN;
    end else begin
      err_code = ERR_NONE;
    end
    word = (err_code == ERR_NONE) ? packed_word : (base & keep_mask);
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: two-stage elastic pipeline around imm_encoder_pack,
// tagging each result with a sequential instruction-memory address.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; ready never depends combinationally on the same port's valid.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        imsrc,
  input  logic [31:0]       imm,
  input  logic [31:0]       base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              err_sticky
);

  logic [31:0] pack_word;
  logic [1:0]  pack_err;

  logic        s1_valid;
  logic [31:0] s1_word;
  logic [1:0]  s1_err;

  logic        s2_adv;
  logic        s1_adv;
  logic        out_fire;

  imm_encoder_pack u_pack (
    .base     (base),
    .imm      (imm),
    .imsrc    (imsrc),
    .word     (pack_word),
    .err_code (pack_err)
  );

  // A stage advances when it is empty or its consumer is taking its contents
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv && !restart;
    out_fire = out_valid && out_ready;
  end

  // Stage 1: capture the checked and packed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= 32'h0;
      s1_err   <= ERR_NONE;
    end else if (restart) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= pack_word;
        s1_err  <= pack_err;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= 32'h0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (restart) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr    <= s1_word;
        err      <= (s1_err != ERR_NONE);
        err_code <= s1_err;
      end
    end
  end

  // Address counter and sticky error flag, both updated on output transfers;
  // error results keep the current address so the next good word reuses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= START_ADDR;
      err_sticky <= 1'b0;
    end else if (restart) begin
      addr       <= START_ADDR;
      err_sticky <= 1'b0;
    end else if (out_fire) begin
      if (err) begin
        err_sticky <= 1'b1;
      end else begin
        addr <= addr + ADDR_W'(4);
      end
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate extender: packs a 32-bit signed immediate into the I/S/B/J instruction bit fields of a supplied base instruction word.
- Range- and alignment-checks the immediate, and tags each result with a sequential instruction-memory word address.
- Sits between the test/program-load path and instruction memory.
- Elastic 2-stage valid/ready pipeline.

Parameters:
- ADDR_W, 32, width of the output address.
- START_ADDR, 0, address of the first emitted instruction after reset or restart.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous flush; returns addr to START_ADDR.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- imsrc  in  2  format: 00=I, 01=S, 10=B, 11=J (same code as the extender).
- imm  in  32  signed immediate, byte offset.
- base  in  32  instruction word; its immediate-field bits are ignored and overwritten.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- instr  out  32  encoded instruction.
- addr  out  ADDR_W  word address for instr.
- err  out  1  this result is invalid.
- err_code  out  2  00=none, 01=RANGE, 10=ALIGN.
- err_sticky  out  1  set by any emitted err result; cleared by reset/restart.

Behaviour:
- Reset: out_valid=0, instr=0, addr=START_ADDR, err=0, err_code=00, err_sticky=0, both stages empty. in_ready=1 after reset.
- Field packing (bits not listed come from base):
  - I: instr[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range rule: imm must equal its own sign-extension from bit 11 (I/S), bit 12 (B) or bit 20 (J); otherwise RANGE.
- Alignment rule: B/J with imm[0]=1 gives ALIGN. RANGE takes priority over ALIGN.
- Error result: err=1, instr=base with the immediate fields zeroed.
- Round-trip invariant: for any in-range, aligned imm, extending the emitted instr yields imm exactly.
- Stage 1 registers the checked and packed word. Stage 2 is the output register.
- Latency: acceptance at cycle N gives out_valid at N+2 when unstalled. Throughput is 1 per cycle.
- Flow control:
  - Each stage advances when it is empty or the next stage is advancing.
  - in_ready = stage-1 empty OR stage 1 advancing. in_ready must not depend combinationally on in_valid.
  - With out_valid=1 and out_ready=0, instr/addr/err hold stable.
  - Stage full and stalled: no overwrite, no loss.
- Address:
  - addr is assigned at the stage2 to output transfer.
  - Increments by 4 (wrapping at 2^ADDR_W) after each error-free output handshake.
  - Error results carry the current addr and do not advance it.
- restart: priority over everything that cycle.
  - Empties both stages, out_valid=0, addr=START_ADDR, err_sticky=0.
  - An in_valid presented in the same cycle is dropped and in_ready=0 that cycle.
- Reset mid-operation discards in-flight data immediately (asynchronous).
- imsrc is fully decoded, so no default case is reachable.

Decomposition:
- Shared package: format codes IMM_I/IMM_S/IMM_B/IMM_J (also used by the extender), err codes ERR_NONE/ERR_RANGE/ERR_ALIGN, range bit positions 11/11/12/20.
- One combinational sub-module, imm_pack: (base, imm, imsrc) -> (word, err_code).
- Top holds the pipeline registers, handshakes and address counter.

Test Plan:
- I: base=0x00000093, imm=0xFFFFFFFF, out_ready=1 -> instr=0xFFF00093, addr=0x0, err=0, out_valid exactly 2 cycles after acceptance.
- S then B back-to-back:
  - base=0x0020A023, imm=8 -> 0x0020A423 at addr 0x0.
  - base=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3 at addr 0x4.
- J then errors:
  - base=0x000000EF, imm=0x800 -> 0x001000EF.
  - I imm=2048 -> err=1, err_code=01, instr=base with fields zeroed, addr not advanced, err_sticky=1.
  - B imm=5 -> err_code=10.
- Backpressure: stream 5 requests with out_ready=0 for 4 cycles.
  - in_ready drops after 2 accepted.
  - Outputs are held stable.
  - All 5 emerge in order at addr 0,4,8,C,10.
- restart with both stages full and in_valid=1 -> next cycle out_valid=0, err_sticky=0; next result at START_ADDR; the concurrent request is not emitted.
- Random round-trip: 1000 in-range aligned imm per format -> a reference extend of instr equals imm; non-immediate bits equal base.
